// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: CPU port, DMA port and the shared memory side.
// The arbiter uses the slave modport; requesters/memory use master.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ready;

    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [DW-1:0] dma_rdata;
    logic          dma_ready;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        output mem_addr, mem_we, mem_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ready, dma_rdata, dma_ready,
        input  mem_addr, mem_we, mem_wdata, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU / DMA) arbiter for the unified core memory: IDLE -> ACCESS -> DONE.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise the CPU wins ties.
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic       we_q;
    logic       gnt_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic       last_q;
`endif

    // Winner of this IDLE cycle: 0 = CPU, 1 = DMA.
    always_comb begin
        gnt_d = bus.dma_req & ~bus.cpu_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.cpu_req && bus.dma_req) gnt_d = ~last_q;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= {AW{1'b0}};
            bus.mem_wdata <= {DW{1'b0}};
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
            bus.cpu_rdata <= {DW{1'b0}};
            bus.dma_rdata <= {DW{1'b0}};
            bus.owner     <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_q        <= 1'b1;
`endif
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.dma_ready <= 1'b0;
            bus.mem_we    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.dma_req) begin
                        bus.owner     <= gnt_d;
                        we_q          <= gnt_d ? bus.dma_we    : bus.cpu_we;
                        bus.mem_we    <= gnt_d ? bus.dma_we    : bus.cpu_we;
                        bus.mem_addr  <= gnt_d ? bus.dma_addr  : bus.cpu_addr;
                        bus.mem_wdata <= gnt_d ? bus.dma_wdata : bus.cpu_wdata;
                        cnt_q         <= '0;
                        state_q       <= ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_q        <= gnt_d;
`endif
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + 4'd1;
                    // Last access cycle: read data is valid now, ready shows in DONE.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        if (bus.owner) begin
                            bus.dma_ready <= 1'b1;
                            if (!we_q) bus.dma_rdata <= bus.mem_rdata;
                        end else begin
                            bus.cpu_ready <= 1'b1;
                            if (!we_q) bus.cpu_rdata <= bus.mem_rdata;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic checked every
// cycle against a transaction-level model (grant time -> expected bus/ready/rdata).
module tb_mem_arbiter;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) bus();
    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    // Backing memory: unwritten words return a fixed pattern, word 16 (0x40) = DEADBEEF.
    function automatic logic [31:0] init_val(input int i);
        return (i == 16) ? 32'hDEADBEEF : 32'(32'h9E3779B9 * (i + 1));
    endfunction

    logic [31:0] mem_arr [256];
    bit   [255:0] mem_vld;
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem_arr[bus.mem_addr[9:2]] <= bus.mem_wdata;
            mem_vld[bus.mem_addr[9:2]] <= 1'b1;
        end
    end
    assign bus.mem_rdata = mem_vld[bus.mem_addr[9:2]] ? mem_arr[bus.mem_addr[9:2]]
                                                      : init_val(int'(bus.mem_addr[9:2]));

    int n_chk = 0, n_pass = 0, cyc = 0, we_cnt = 0;

    // Reference model state: one in-flight transaction described by its grant cycle.
    bit          have_tx;
    int          tx_p, tx_s;
    logic        tx_we;
    logic [31:0] tx_addr, tx_wd;
    logic [31:0] exp_rd [2];
    logic        last_g;
    logic [31:0] mem_m [256];

    // Requesters.
    bit          pend [2], drop [2], rereq [2], rdy_obs [2];
    logic        rq_we [2];
    logic [31:0] rq_addr [2], rq_wd [2];
    int          last_rdy_cyc [2];
    int          own_q [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic new_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        pend[p] = 1'b1; drop[p] = 1'b0;
        rq_we[p] = we; rq_addr[p] = a; rq_wd[p] = d;
    endtask

    task automatic compare();
        bit rdy_e [2];
        rdy_e = '{1'b0, 1'b0};
        if (have_tx && cyc >= tx_s + LAT + 2) have_tx = 1'b0;
        if (have_tx && tx_we && cyc == tx_s + 2) mem_m[tx_addr[9:2]] = tx_wd;
        if (have_tx && cyc == tx_s + LAT + 1) begin
            rdy_e[tx_p] = 1'b1;
            if (!tx_we) exp_rd[tx_p] = mem_m[tx_addr[9:2]];
            chk("owner_done", bus.owner, tx_p);
        end
        chk("mem_we", bus.mem_we, have_tx && tx_we && cyc == tx_s + 1);
        if (have_tx && cyc > tx_s && cyc <= tx_s + LAT) begin
            chk("mem_addr", bus.mem_addr, tx_addr);
            chk("owner", bus.owner, tx_p);
            if (tx_we) chk("mem_wdata", bus.mem_wdata, tx_wd);
        end
        chk("cpu_ready", bus.cpu_ready, rdy_e[0]);
        chk("dma_ready", bus.dma_ready, rdy_e[1]);
        chk("cpu_rdata", bus.cpu_rdata, exp_rd[0]);
        chk("dma_rdata", bus.dma_rdata, exp_rd[1]);
        if (bus.mem_we) we_cnt++;
        rdy_obs[0] = bus.cpu_ready;
        rdy_obs[1] = bus.dma_ready;
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        compare();
        if (rdy_obs[0] || rdy_obs[1]) own_q.push_back(int'(bus.owner));
        for (int p = 0; p < 2; p++) begin
            if (rdy_obs[p]) begin
                last_rdy_cyc[p] = cyc;
                pend[p] = 1'b0; drop[p] = 1'b0;
                if (rereq[p]) new_req(p, 1'b0, rq_addr[p], 32'h0);
            end
        end
    endtask

    // Drive the bus for this cycle and predict what the IDLE arbitration will do.
    task automatic commit();
        int g;
        bus.cpu_req = pend[0] && !drop[0]; bus.cpu_we = rq_we[0];
        bus.cpu_addr = rq_addr[0];         bus.cpu_wdata = rq_wd[0];
        bus.dma_req = pend[1] && !drop[1]; bus.dma_we = rq_we[1];
        bus.dma_addr = rq_addr[1];         bus.dma_wdata = rq_wd[1];
        if (!have_tx && (bus.cpu_req || bus.dma_req)) begin
            if (bus.cpu_req && bus.dma_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                g = last_g ? 0 : 1;
`else
                g = 0;
`endif
            end else g = bus.dma_req ? 1 : 0;
            last_g = g[0];
            have_tx = 1'b1; tx_p = g; tx_s = cyc;
            tx_we = rq_we[g]; tx_addr = rq_addr[g]; tx_wd = rq_wd[g];
        end
    endtask

    task automatic rand_stim();
        for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
                if ($urandom_range(2) == 0)
                    new_req(p, 1'($urandom_range(1)), 32'($urandom_range(255) * 4), $urandom);
            end else if (have_tx && tx_p == p && cyc > tx_s) begin
                // Owner's fields are already latched: scramble them, sometimes drop req.
                rq_addr[p] = 32'($urandom_range(255) * 4);
                rq_we[p]   = 1'($urandom_range(1));
                rq_wd[p]   = $urandom;
                if ($urandom_range(3) == 0) drop[p] = 1'b1;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((pend[0] || pend[1]) && n < budget) begin
            tick(); commit(); n++;
        end
        chk("drain_timeout", {31'b0, pend[0] || pend[1]}, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        for (int i = 0; i < 256; i++) mem_m[i] = init_val(i);
        exp_rd = '{32'h0, 32'h0};
        last_g = 1'b1; have_tx = 1'b0;
        for (int p = 0; p < 2; p++) begin
            pend[p] = 0; drop[p] = 0; rereq[p] = 0; rq_we[p] = 0; rq_addr[p] = 0; rq_wd[p] = 0;
        end
        rst = 1'b1;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = 0; bus.dma_wdata = 0;
        #1;
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_dma_ready", bus.dma_ready, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dma_rdata", bus.dma_rdata, 0);
        chk("rst_owner", bus.owner, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        commit();

        // Both ports tie from a fresh reset and keep re-requesting.
        tick();
        new_req(0, 1'b0, 32'h40, 32'h0);
        new_req(1, 1'b0, 32'h100, 32'h0);
        rereq[0] = 1'b1; rereq[1] = 1'b1;
        own_q.delete();
        commit();
        for (int n = 0; n < 200 && own_q.size() < 6; n++) begin tick(); commit(); end
        rereq[0] = 1'b0; rereq[1] = 1'b0;
        chk("tie_count", own_q.size() >= 6, 1);
        for (int i = 0; i < 6 && i < own_q.size(); i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk("tie_owner_seq", own_q[i], i % 2);
`else
            chk("tie_owner_seq", own_q[i], 0);
`endif
        end
        wait_idle(100);

        // Single CPU read of 0x40.
        tick(); new_req(0, 1'b0, 32'h40, 32'h0); s0 = cyc; commit();
        wait_idle(50);
        chk("cpu_rd_latency", last_rdy_cyc[0] - s0, LAT + 1);
        chk("cpu_rd_beef", bus.cpu_rdata, 32'hDEADBEEF);

        // DMA write: exactly one strobe, then read it back through the CPU.
        tick(); we_cnt = 0; new_req(1, 1'b1, 32'h100, 32'h12345678); s0 = cyc; commit();
        wait_idle(50);
        chk("dma_wr_strobes", we_cnt, 1);
        chk("dma_wr_latency", last_rdy_cyc[1] - s0, LAT + 1);
        tick(); new_req(0, 1'b0, 32'h100, 32'h0); commit();
        wait_idle(50);
        chk("cpu_readback", bus.cpu_rdata, 32'h12345678);

        // Reset in the first ACCESS cycle of a CPU write.
        tick(); new_req(0, 1'b1, 32'h80, 32'hCAFEF00D); commit();
        tick();
        rst = 1'b1;
        #1;
        chk("abort_mem_we", bus.mem_we, 0);
        chk("abort_cpu_ready", bus.cpu_ready, 0);
        chk("abort_cpu_rdata", bus.cpu_rdata, 0);
        chk("abort_dma_rdata", bus.dma_rdata, 0);
        have_tx = 1'b0; exp_rd = '{32'h0, 32'h0}; last_g = 1'b1;
        @(negedge clk); cyc++;
        chk("abort_no_ready", bus.cpu_ready, 0);
        rst = 1'b0;
        s0 = cyc;
        commit();
        wait_idle(50);
        chk("abort_recover_lat", last_rdy_cyc[0] - s0, LAT + 1);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin tick(); rand_stim(); commit(); end
        wait_idle(300);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single unified instruction/data memory of the multicycle RISC-V core. It shares that memory between the core's multicycle control path (port 0, CPU) and a program loader/DMA engine (port 1). It serializes their accesses through a small FSM with a req/ready handshake and returns read data to the owning requester.

## Interface
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from address presented to valid mem_rdata; legal range 1..15
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request; held until cpu_ready
- cpu_we  input  1  CPU write enable (1 write, 0 read)
- cpu_addr  input  AW  CPU byte address
- cpu_wdata  input  DW  CPU write data
- cpu_rdata  output  DW  CPU read data, registered
- cpu_ready  output  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ready: same as the cpu_* signals, for port 1
- mem_addr  output  AW  memory address
- mem_we  output  1  memory write strobe
- mem_wdata  output  DW  memory write data
- mem_rdata  input  DW  memory read data
- owner  output  1  port holding the memory (0 CPU, 1 DMA); valid outside IDLE

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req is high, select a winner. Latch its we/addr/wdata and set owner. Go to ACCESS with cnt=0. With no req, stay in IDLE.
- ACCESS: mem_addr/mem_wdata driven from the latched values for MEM_LAT cycles. mem_we=latched we only while cnt==0, so there is exactly one write strobe per write. cnt increments each cycle.
  - At cnt==MEM_LAT-1 on a read, capture mem_rdata into the owner's rdata register.
  - Then go to DONE.
- DONE: the owner's ready=1 for this single cycle. Next state is IDLE.
- Selection when both ports request: see Configuration. A single requester always wins.
- rdata registers hold their value until the next completed read on the same port. Writes never modify rdata.
- The non-owner's ready and rdata are untouched during the other port's transaction.
- Requester contract: drop req in the cycle after ready. A req still high in IDLE is treated as a new request.
- A req withdrawn after being latched does not cancel the access; ready still pulses.
- Request inputs changing while not in IDLE are ignored. Addr/we/wdata are latched only in IDLE.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, cnt=0
  - mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_ready=dma_ready=0, cpu_rdata=dma_rdata=0
  - owner=0, last_grant=1
- All outputs are registered; there is no combinational path from req to mem_*.
- Latency: req first high in IDLE cycle t gives mem_addr valid t+1 through t+MEM_LAT, and ready at t+MEM_LAT+1.
  - MEM_LAT=1: req at cycle 0, ready at cycle 2.
- Throughput: one access per MEM_LAT+2 cycles. A back-to-back request is arbitrated in the IDLE cycle following DONE.
- Simultaneous requests in IDLE: exactly one grant. The loser stays pending with no ready until served.
- Reset mid-ACCESS or mid-DONE: the transaction is aborted. No ready pulse is produced, mem_we drops immediately, and rdata is cleared to 0.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: on a tie, grant the port opposite last_grant. last_grant updates on every grant. Because last_grant resets to 1, the first tie goes to the CPU, and ties alternate afterwards.
- Not defined: fixed priority, where CPU always wins ties and the DMA can starve while cpu_req is continuously asserted. last_grant is not implemented.

## Test plan
- Single CPU read, MEM_LAT=1, memory returns 0xDEADBEEF at 0x40: cpu_req at cycle 0 → mem_addr=0x40 at cycle 1, cpu_ready=1 and cpu_rdata=0xDEADBEEF at cycle 2, dma_ready stays 0.
- DMA write 0x12345678 to 0x100, MEM_LAT=3 → mem_we high for exactly 1 cycle (cycle 1), mem_addr=0x100 for cycles 1–3, dma_ready at cycle 4, dma_rdata unchanged.
- Both ports request reads at cycle 0 and hold requests through completion, MEM_LAT=1:
  - With MEM_ARB_ROUND_ROBIN_EN: cpu_ready at cycle 2, dma_ready at cycle 5.
  - Without it: cpu_ready at cycle 2, and with the CPU re-requesting, cpu_ready again at cycle 5 while dma_ready stays 0.
- Round-robin, both ports continuously re-requesting for 6 transactions → owner sequence 0,1,0,1,0,1.
- rst asserted at cycle 1 of a CPU read (mid-ACCESS) → mem_we=0 and state IDLE immediately, no cpu_ready pulse, cpu_rdata=0. After rst release, a pending cpu_req completes normally in MEM_LAT+2 cycles.
